// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 status, icode, register-id and M/W bundle definitions
package y86_pkg;

  localparam int WORD_W = 64;

  // Processor status codes carried down the pipe with each instruction
  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Contents of the M/W pipeline register
  typedef struct packed {
    logic              valid;
    stat_e             stat;
    logic [3:0]        icode;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valM;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } mw_t;

  // A nop that writes nothing; what W holds out of reset or after a bubble
  function automatic mw_t mw_bubble();
    mw_t b;
    b.valid = 1'b0;
    b.stat  = SAOK;
    b.icode = INOP;
    b.valE  = '0;
    b.valM  = '0;
    b.dstE  = RNONE;
    b.dstM  = RNONE;
    return b;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15-entry register file, two async read ports, two write ports
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs [0:NREG-1];

  // Per-register write; port M wins when both ports target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && dst_m == 4'(i))
          regs[i] <= val_m;
        else if (we_e && dst_e == 4'(i))
          regs[i] <= val_e;
      end
    end
  end

  // Reads come straight from the array; RNONE (and any id past the array) reads zero
  assign val_a = (src_a != RNONE && src_a < 4'(NREG)) ? regs[src_a] : '0;
  assign val_b = (src_b != RNONE && src_b < 4'(NREG)) ? regs[src_b] : '0;

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 writeback: W register, commit, sticky halt, retire count
module writeback_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [2:0]        w_stat,
  output logic [3:0]        w_dstE,
  output logic [3:0]        w_dstM,
  output logic [DATA_W-1:0] w_valE,
  output logic [DATA_W-1:0] w_valM,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  // The M/W bundle is sized by the package word width
  if (DATA_W != WORD_W) begin : g_width_check
    $error("writeback_stage: DATA_W must equal y86_pkg::WORD_W");
  end

  mw_t              w_q;
  mw_t              m_bundle;
  logic             halted_q;
  logic             counted_q;
  logic [CNT_W-1:0] retired_q;
  logic             w_hold;
  logic             commit_en;
  logic             count_en;

  assign m_bundle.valid = m_valid;
  assign m_bundle.stat  = stat_e'(m_stat);
  assign m_bundle.icode = m_icode;
  assign m_bundle.valE  = m_valE;
  assign m_bundle.valM  = m_valM;
  assign m_bundle.dstE  = m_dstE;
  assign m_bundle.dstM  = m_dstM;

  assign w_hold    = halted_q || w_stall;
  assign commit_en = w_q.valid && (w_q.stat == SAOK) && !halted_q;
  // A stalled entry re-commits every cycle but is only counted the first time
  assign count_en  = commit_en && !counted_q;

  // W register: halt and stall hold, stall beats bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      w_q <= mw_bubble();
    else if (!w_hold)
      w_q <= w_bubble ? mw_bubble() : m_bundle;
  end

  // Sticky halt once a faulting or halting instruction reaches W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted_q <= 1'b0;
    else if (w_q.valid && (w_q.stat != SAOK))
      halted_q <= 1'b1;
  end

  // Retire counter plus a flag marking that the current W entry was already counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      counted_q <= 1'b0;
    end else begin
      if (count_en)
        retired_q <= retired_q + 1'b1;
      if (!w_hold)
        counted_q <= 1'b0;
      else if (count_en)
        counted_q <= 1'b1;
    end
  end

  y86_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (d_valA),
    .val_b (d_valB),
    .we_e  (commit_en && (w_q.dstE != RNONE)),
    .dst_e (w_q.dstE),
    .val_e (w_q.valE),
    .we_m  (commit_en && (w_q.dstM != RNONE)),
    .dst_m (w_q.dstM),
    .val_m (w_q.valM)
  );

  assign w_stat  = w_q.stat;
  assign w_dstE  = w_q.dstE;
  assign w_dstM  = w_q.dstM;
  assign w_valE  = w_q.valE;
  assign w_valM  = w_q.valM;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        w_stall;
  logic        w_bubble;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_valA;
  logic [63:0] d_valB;
  logic [2:0]  w_stat;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic        halted;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DATA_W(64), .NREG(15), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .m_stat   (m_stat),
    .m_icode  (m_icode),
    .m_valE   (m_valE),
    .m_valM   (m_valM),
    .m_dstE   (m_dstE),
    .m_dstM   (m_dstM),
    .w_stall  (w_stall),
    .w_bubble (w_bubble),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_valA   (d_valA),
    .d_valB   (d_valB),
    .w_stat   (w_stat),
    .w_dstE   (w_dstE),
    .w_dstM   (w_dstM),
    .w_valE   (w_valE),
    .w_valM   (w_valM),
    .halted   (halted),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] stat, input logic [3:0] icode,
                       input logic [3:0] dste, input logic [63:0] vale,
                       input logic [3:0] dstm, input logic [63:0] valm);
    m_valid = 1'b1;
    m_stat  = stat;
    m_icode = icode;
    m_dstE  = dste;
    m_valE  = vale;
    m_dstM  = dstm;
    m_valM  = valm;
  endtask

  task automatic idle();
    m_valid = 1'b0;
    m_stat  = 3'd1;
    m_icode = 4'h1;
    m_dstE  = 4'hF;
    m_dstM  = 4'hF;
    m_valE  = '0;
    m_valM  = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    d_srcA   = 4'h0;
    d_srcB   = 4'h0;
    idle();
    step();
    step();

    // Reset state
    check("rst_w_stat", 64'(w_stat), 64'd1);
    check("rst_w_dstE", 64'(w_dstE), 64'hF);
    check("rst_w_dstM", 64'(w_dstM), 64'hF);
    check("rst_w_valE", w_valE, 64'h0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_rax", d_valA, 64'h0);

    rst_n = 1'b1;

    // irmovq to rax: latched at edge N, committed at N+1
    drive(3'd1, 4'h3, 4'h0, 64'h1122334455667788, 4'hF, 64'h0);
    step();
    idle();
    check("t1_w_valE", w_valE, 64'h1122334455667788);
    check("t1_w_dstE", 64'(w_dstE), 64'h0);
    check("t1_no_bypass", d_valA, 64'h0);
    step();
    check("t1_rax", d_valA, 64'h1122334455667788);
    check("t1_retired", 64'(retired), 64'd1);

    // popq %rsp: both destinations are rsp, valM wins
    drive(3'd1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h200);
    step();
    idle();
    step();
    d_srcB = 4'h4;
    #1;
    check("t2_rsp", d_valB, 64'h200);
    check("t2_retired", 64'(retired), 64'd2);

    // Stall with an rcx write in W: written, counted once, outputs frozen
    drive(3'd1, 4'h3, 4'h1, 64'h33, 4'hF, 64'h0);
    step();
    w_stall = 1'b1;
    drive(3'd1, 4'h3, 4'h2, 64'h77, 4'hF, 64'h0);
    for (int i = 0; i < 3; i++) step();
    d_srcA = 4'h1;
    #1;
    check("t3_rcx", d_valA, 64'h33);
    check("t3_retired", 64'(retired), 64'd3);
    check("t3_w_dstE", 64'(w_dstE), 64'h1);
    check("t3_w_valE", w_valE, 64'h33);
    w_bubble = 1'b1;
    step();
    check("t3_stall_bubble_dstE", 64'(w_dstE), 64'h1);
    check("t3_stall_bubble_valE", w_valE, 64'h33);
    check("t3_stall_bubble_ret", 64'(retired), 64'd3);
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    step();
    idle();
    check("t3_release_ret", 64'(retired), 64'd3);
    check("t3_release_dstE", 64'(w_dstE), 64'h2);
    step();
    d_srcA = 4'h2;
    #1;
    check("t3_rdx", d_valA, 64'h77);
    check("t3_rdx_ret", 64'(retired), 64'd4);

    // Bubble replaces a presented instruction; no write
    drive(3'd1, 4'h3, 4'h5, 64'hAA, 4'hF, 64'h0);
    w_bubble = 1'b1;
    step();
    w_bubble = 1'b0;
    idle();
    check("t4_w_stat", 64'(w_stat), 64'd1);
    check("t4_w_dstE", 64'(w_dstE), 64'hF);
    check("t4_w_valE", w_valE, 64'h0);
    step();
    d_srcA = 4'h5;
    d_srcB = 4'hF;
    #1;
    check("t4_rbp", d_valA, 64'h0);
    check("t4_rnone", d_valB, 64'h0);
    check("t4_retired", 64'(retired), 64'd4);

    // Halt: rbx=5, then HLT targeting rbx
    drive(3'd1, 4'h3, 4'h3, 64'h5, 4'hF, 64'h0);
    step();
    drive(3'd2, 4'h0, 4'h3, 64'h9, 4'hF, 64'h0);
    step();
    check("t5_pre_halted", 64'(halted), 64'd0);
    check("t5_pre_ret", 64'(retired), 64'd5);
    drive(3'd1, 4'h3, 4'h6, 64'h66, 4'hF, 64'h0);
    step();
    check("t5_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) step();
    d_srcA = 4'h3;
    d_srcB = 4'h6;
    #1;
    check("t5_rbx", d_valA, 64'h5);
    check("t5_rsi", d_valB, 64'h0);
    check("t5_retired", 64'(retired), 64'd5);
    check("t5_still_halted", 64'(halted), 64'd1);
    idle();

    // Asynchronous reset mid-cycle clears halt immediately
    #2 rst_n = 1'b0;
    #1;
    check("t6_halt_clr", 64'(halted), 64'd0);
    check("t6_rbx_clr", d_valA, 64'h0);
    #1 rst_n = 1'b1;

    // r14 write, then mid-cycle reset
    drive(3'd1, 4'h3, 4'hE, 64'hFFFFFFFFFFFFFFFF, 4'hF, 64'h0);
    step();
    idle();
    step();
    d_srcA = 4'hE;
    #1;
    check("t7_r14", d_valA, 64'hFFFFFFFFFFFFFFFF);
    check("t7_ret", 64'(retired), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_r14_clr", d_valA, 64'h0);
    check("t7_ret_clr", 64'(retired), 64'd0);
    check("t7_halted", 64'(halted), 64'd0);
    check("t7_w_dstE", 64'(w_dstE), 64'hF);
    #1 rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
